ahbl_mm_arbiter: RTL



---
 rtl/ahbl_mm_arbiter.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ahbl_mm_arbiter.sv
// ---------------------------------------------------------------------------
// ahbl_mm_arbiter
//
// N-master AHB-lite arbiter that places several masters (CPU, DMA, debug) in
// front of the single slave-side bus that feeds the system decoder.
//
// Each master port has a hold stage. A transfer that a port issues while it
// cannot drive the slave bus directly is captured there. The master then
// sees wait states until the arbiter replays the transfer.
//
// Parameters:
//   NUM_MASTERS  number of master ports (2..8)
//   AW, DW       address / data width
//   ARB_MODE     0 = fixed priority (port 0 highest), 1 = round-robin
//
// Ports:
//   HCLK, HRESET        clock, synchronous active-high reset
//   M_HADDR/HTRANS/HWRITE/HSIZE/HWDATA
//                       per-port master request buses, packed; port m
//                       occupies slice [m*W +: W]
//   M_HREADY            per-port ready back to the masters
//   M_HRDATA            read data, broadcast to all ports
//   S_HADDR/HTRANS/HWRITE/HSIZE/HWDATA
//                       slave-side address/control and write data
//   S_HREADY, S_HRDATA  slave-side ready and read data
//   GRANT               one-hot owner of the address phase
//
// Optional feature (macro AHBL_ARB_LOCK_EN):
//   Adds the M_HMASTLOCK input and the S_HMASTLOCK output. The lock bit is
//   captured with the transfer. A locked owner keeps the grant until it
//   presents an unlocked transfer or IDLE.
//
// Handshake:
//   A port issues a transfer when HTRANS[1]=1 and its M_HREADY=1 in the same
//   cycle. The slave accepts an address phase when S_HTRANS[1]=1 and
//   S_HREADY=1. A data phase ends on the first S_HREADY=1 cycle after it
//   starts.
// ---------------------------------------------------------------------------
module ahbl_mm_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int ARB_MODE    = 1
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [NUM_MASTERS*AW-1:0] M_HADDR,
  input  logic [2*NUM_MASTERS-1:0]  M_HTRANS,
  input  logic [NUM_MASTERS-1:0]    M_HWRITE,
  input  logic [3*NUM_MASTERS-1:0]  M_HSIZE,
  input  logic [NUM_MASTERS*DW-1:0] M_HWDATA,
`ifdef AHBL_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]    M_HMASTLOCK,
  output logic                      S_HMASTLOCK,
`endif
  output logic [NUM_MASTERS-1:0]    M_HREADY,
  output logic [DW-1:0]             M_HRDATA,
  output logic [AW-1:0]             S_HADDR,
  output logic [1:0]                S_HTRANS,
  output logic                      S_HWRITE,
  output logic [2:0]                S_HSIZE,
  output logic [DW-1:0]             S_HWDATA,
  input  logic                      S_HREADY,
  input  logic [DW-1:0]             S_HRDATA,
  output logic [NUM_MASTERS-1:0]    GRANT
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Arbitration and data-phase state
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          downer_q, downer_d;
  logic                   dvalid_q, dvalid_d;
  logic [NUM_MASTERS-1:0] pend_q, pend_d;

  // Per-port hold stage
  logic [AW-1:0]          hold_addr_q  [NUM_MASTERS];
  logic [1:0]             hold_trans_q [NUM_MASTERS];
  logic [2:0]             hold_size_q  [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] hold_write_q;
`ifdef AHBL_ARB_LOCK_EN
  logic [NUM_MASTERS-1:0] hold_lock_q;
  logic                   src_lock;
`endif

  // Unpacked views of the live master buses
  logic [AW-1:0]          live_addr  [NUM_MASTERS];
  logic [1:0]             live_trans [NUM_MASTERS];
  logic [2:0]             live_size  [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] mready;
  logic [NUM_MASTERS-1:0] issue;
  logic [NUM_MASTERS-1:0] capture;
  logic [NUM_MASTERS-1:0] req;
  logic                   src_hold;
  logic [1:0]             src_trans;
  logic                   accept;
  logic                   arb_en;
  logic                   found;
  int                     idx;

  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      live_addr[m]  = M_HADDR[m*AW +: AW];
      live_trans[m] = M_HTRANS[m*2 +: 2];
      live_size[m]  = M_HSIZE[m*3 +: 3];
    end
  end

  always_comb begin
    // Per-port ready. A port in its data phase follows the slave. A port
    // with a held transfer is stalled until the replay's data phase.
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (HRESET)
        mready[m] = 1'b1;
      else if (dvalid_q && (downer_q == IW'(m)))
        mready[m] = S_HREADY;
      else if (pend_q[m])
        mready[m] = 1'b0;
      else
        mready[m] = 1'b1;
      issue[m] = ~HRESET & live_trans[m][1] & mready[m];
    end

    // Slave address mux: the owner's held transfer takes precedence over
    // its live inputs.
    src_hold  = pend_q[owner_q];
    src_trans = src_hold ? hold_trans_q[owner_q] : live_trans[owner_q];
    S_HADDR   = src_hold ? hold_addr_q[owner_q]  : live_addr[owner_q];
    S_HWRITE  = src_hold ? hold_write_q[owner_q] : M_HWRITE[owner_q];
    S_HSIZE   = src_hold ? hold_size_q[owner_q]  : live_size[owner_q];
    S_HTRANS  = HRESET ? HTRANS_IDLE : src_trans;
    accept    = S_HTRANS[1] & S_HREADY;

    // Capture everything issued except the owner's zero-latency pass-through.
    for (int m = 0; m < NUM_MASTERS; m++) begin
      capture[m] = issue[m] &
                   ~((owner_q == IW'(m)) & ~pend_q[m] & S_HREADY);
    end

    pend_d = pend_q | capture;
    if (accept && src_hold)
      pend_d[owner_q] = 1'b0;

    dvalid_d = dvalid_q;
    downer_d = downer_q;
    if (accept) begin
      dvalid_d = 1'b1;
      downer_d = owner_q;
    end else if (S_HREADY) begin
      dvalid_d = 1'b0;
    end

    // Arbitration. A SEQ beat from the owner holds the grant so that bursts
    // are never split.
`ifdef AHBL_ARB_LOCK_EN
    src_lock    = src_hold ? hold_lock_q[owner_q] : M_HMASTLOCK[owner_q];
    S_HMASTLOCK = src_lock & ~HRESET;
    arb_en      = S_HREADY & (src_trans != HTRANS_SEQ) &
                  ~(src_lock & (src_trans != HTRANS_IDLE));
`else
    arb_en      = S_HREADY & (src_trans != HTRANS_SEQ);
`endif

    for (int m = 0; m < NUM_MASTERS; m++)
      req[m] = pend_q[m] | ((live_trans[m] == HTRANS_NONSEQ) & mready[m]);

    owner_d = owner_q;
    found   = 1'b0;
    idx     = 0;
    if (arb_en) begin
      if (ARB_MODE == 0) begin
        for (int k = 0; k < NUM_MASTERS; k++) begin
          if (!found && req[k]) begin
            found   = 1'b1;
            owner_d = IW'(k);
          end
        end
      end else begin
        // Search starts just after the current owner; the owner is last.
        for (int k = 1; k <= NUM_MASTERS; k++) begin
          idx = (int'(owner_q) + k) % NUM_MASTERS;
          if (!found && req[idx]) begin
            found   = 1'b1;
            owner_d = IW'(idx);
          end
        end
      end
    end

    M_HREADY = mready;
    M_HRDATA = S_HRDATA;
    S_HWDATA = M_HWDATA[int'(downer_q)*DW +: DW];

    GRANT = '0;
    if (HRESET)
      GRANT[0] = 1'b1;
    else
      GRANT[owner_q] = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner_q  <= '0;
      downer_q <= '0;
      dvalid_q <= 1'b0;
      pend_q   <= '0;
    end else begin
      owner_q  <= owner_d;
      downer_q <= downer_d;
      dvalid_q <= dvalid_d;
      pend_q   <= pend_d;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (capture[m]) begin
          hold_addr_q[m]  <= live_addr[m];
          hold_trans_q[m] <= live_trans[m];
          hold_size_q[m]  <= live_size[m];
          hold_write_q[m] <= M_HWRITE[m];
`ifdef AHBL_ARB_LOCK_EN
          hold_lock_q[m]  <= M_HMASTLOCK[m];
`endif
        end
      end
    end
  end

endmodule
